stack_frame_writer: RTL and testbench
=====================================

// Module: stack_frame_writer
// PURPOSE
//  Write-side engine for the stack BRAM frame format. Accepts a stream of active
//  entries (spike indices) and writes them to consecutive addresses base+1.. of a frame.
//  On close, it writes the entry count into the frame's first word (base), which the
//  pop logic reads as its active-entry header.
//  Sits between a spike/index producer and the stack memory write port.
// PARAMETERS
//  DATA_WIDTH   10    width of entries and of the count header word
//  ADDR_WIDTH   12    stack memory address width (covers 3468-word stack)
//  FRAME_DEPTH  128   words per frame incl. header; payload capacity FRAME_DEPTH-1
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous active-high reset
//  clr          in   1           synchronous clear, same effect as rst
//  start        in   1           open frame at frame_baddr (accepted in IDLE only)
//  frame_baddr  in   ADDR_WIDTH  frame base address (header location)
//  in_valid     in   1           entry valid
//  in_data      in   DATA_WIDTH  entry value
//  in_last      in   1           qualifies in_valid: this entry closes the frame
//  close        in   1           close frame without a data beat (empty/explicit end)
//  in_ready     out  1           writer accepts an entry this cycle
//  mem_wr_en    out  1           stack write enable (registered)
//  mem_waddr    out  ADDR_WIDTH  stack write address (registered)
//  mem_wdata    out  DATA_WIDTH  stack write data (registered)
//  busy         out  1           frame open (state != IDLE)
//  done         out  1           1-cycle pulse: header written, frame complete
//  count        out  DATA_WIDTH  entries stored in current/last frame
//  overflow     out  1           sticky per frame: entries dropped because frame was full
// BEHAVIOUR
//  Reset/clr: state=IDLE; all outputs 0; base_q=0, cnt=0. A mid-frame reset aborts
//   the frame. No header is written.
//  FSM: IDLE -> FILL -> COMMIT -> DONE -> IDLE.
//  IDLE: in_ready=0. start=1 -> base_q<=frame_baddr, cnt<=0, overflow<=0, go FILL.
//   in_valid/close are ignored.
//  FILL: in_ready=1. Accept = in_valid&in_ready.
//   Accept with cnt<FRAME_DEPTH-1: next cycle mem_wr_en=1, mem_waddr=base_q+1+cnt,
//   mem_wdata=in_data; cnt<=cnt+1.
//   Accept with cnt==FRAME_DEPTH-1: no write, cnt holds, overflow<=1.
//   Accept with in_last=1, or close=1 -> go COMMIT.
//   If in_last beat and close arrive in the same cycle, the beat is accepted and
//   only one commit occurs.
//  COMMIT: in_ready=0. Next cycle mem_wr_en=1, mem_waddr=base_q, mem_wdata=cnt
//   (final count, zero-extended). Go DONE.
//  DONE: done=1 for exactly one cycle. Go IDLE. count holds until the next start.
//  Latency: memory write is 1 cycle after the accepting edge. Header write is 1 cycle
//   after the last data write. done is asserted in the same cycle as the header
//   mem_wr_en. start->first in_ready is 1 cycle.
//  start while busy is ignored (no re-latch of base, no count reset).
//  Address arithmetic is modulo 2^ADDR_WIDTH (base_q+1+cnt wraps, no error).
//  mem_wr_en is never high on two different addresses in the same cycle. Back-to-back
//   writes on consecutive cycles are allowed (one per accepted beat).
//  FRAME_DEPTH-1 must be representable in DATA_WIDTH bits (elaboration check).
// TESTING
//  T1: start, base=128; 3 beats 5,9,17 (last on 17) -> writes 129<=5,130<=9,131<=17,
//      then 128<=3 with done=1, overflow=0.
//  T2: start, base=256; close with no beats -> single write 256<=0, done=1, count=0.
//  T3: FRAME_DEPTH=4; start, base=0; 5 beats 1..5 -> writes 1<=1,2<=2,3<=3, header 0<=3,
//      overflow=1.
//  T4: start base=128 then start base=512 during FILL, 1 beat 7 last ->
//      129<=7, 128<=1; address 512 is untouched.
//  T5: ADDR_WIDTH=12, base=4094; 2 beats -> writes 4095, 0, header 4094<=2.
//  T6: rst asserted after 2 beats in FILL -> no header write, outputs 0, in_ready=0;
//      a new start works normally.

Source files
------------

// File: rtl/stack_frame_writer.sv
// stack_frame_writer: streams entries into stack frame words base+1.. then writes the entry count as header at base
module stack_frame_writer #(
  parameter int DATA_WIDTH  = 10,
  parameter int ADDR_WIDTH  = 12,
  parameter int FRAME_DEPTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] frame_baddr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  close,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  overflow
);
  if (FRAME_DEPTH - 1 >= (1 << DATA_WIDTH)) begin : g_chk
    $error("FRAME_DEPTH-1 does not fit in DATA_WIDTH");
  end
  localparam logic [DATA_WIDTH-1:0] CAP = DATA_WIDTH'(FRAME_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, FILL, COMMIT, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d, wdata_q, wdata_d;
  logic                  ovf_q, ovf_d, wr_en_q, wr_en_d;
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wr_en_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        base_d  = frame_baddr;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      FILL: begin
        if (in_valid) begin
          if (cnt_q == CAP) ovf_d = 1'b1;
          else begin
            wr_en_d = 1'b1;
            waddr_d = base_q + ADDR_WIDTH'(1) + ADDR_WIDTH'(cnt_q);
            wdata_d = in_data;
            cnt_d   = cnt_q + DATA_WIDTH'(1);
          end
        end
        if ((in_valid && in_last) || close) state_d = COMMIT;
      end
      COMMIT: begin
        wr_en_d = 1'b1;
        waddr_d = base_q;
        wdata_d = cnt_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      wr_en_q <= wr_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign in_ready  = state_q == FILL;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign mem_wr_en = wr_en_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_stack_frame_writer.sv
// tb_stack_frame_writer: directed checks of frame writes, header commit, overflow, wrap and abort
module tb_stack_frame_writer;
  logic        clk = 0, rst = 1, clr = 0, start = 0, in_valid = 0, in_last = 0, close = 0;
  logic [11:0] frame_baddr = '0;
  logic [9:0]  in_data = '0;
  logic        in_ready, mem_wr_en, busy, done, overflow;
  logic [11:0] mem_waddr;
  logic [9:0]  mem_wdata, count;
  int vec = 0, miss = 0;
  stack_frame_writer #(.DATA_WIDTH(10), .ADDR_WIDTH(12), .FRAME_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .frame_baddr(frame_baddr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .close(close),
    .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .count(count), .overflow(overflow));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wr(input string tag, input logic en, input logic [11:0] a, input logic [9:0] d);
    chk({tag, ".wr_en"}, 32'(mem_wr_en), 32'(en));
    if (en) begin
      chk({tag, ".addr"}, 32'(mem_waddr), 32'(a));
      chk({tag, ".data"}, 32'(mem_wdata), 32'(d));
    end
  endtask
  task automatic beat(input logic [9:0] d, input logic l);
    in_valid = 1; in_data = d; in_last = l;
  endtask
  task automatic open(input logic [11:0] b);
    start = 1; frame_baddr = b;
    tick();
    start = 0;
  endtask
  task automatic idle_in;
    in_valid = 0; in_last = 0; close = 0;
  endtask
  initial begin
    @(negedge clk);
    tick(); tick();
    chk("rst.wr_en", 32'(mem_wr_en), 0);
    chk("rst.addr", 32'(mem_waddr), 0);
    chk("rst.data", 32'(mem_wdata), 0);
    chk("rst.ready", 32'(in_ready), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.ovf", 32'(overflow), 0);
    rst = 0;
    beat(10'd99, 1); tick(); idle_in();
    wr("idle_ignore", 0, 0, 0);
    chk("idle.busy", 32'(busy), 0);
    // T1
    open(12'd128);
    chk("t1.ready", 32'(in_ready), 1);
    chk("t1.busy", 32'(busy), 1);
    beat(10'd5, 0); tick(); wr("t1.b0", 1, 129, 5);
    beat(10'd9, 0); tick(); wr("t1.b1", 1, 130, 9);
    beat(10'd17, 1); tick(); wr("t1.b2", 1, 131, 17);
    chk("t1.commit_ready", 32'(in_ready), 0);
    chk("t1.commit_done", 32'(done), 0);
    idle_in(); tick(); wr("t1.hdr", 1, 128, 3);
    chk("t1.done", 32'(done), 1);
    chk("t1.ovf", 32'(overflow), 0);
    chk("t1.count", 32'(count), 3);
    tick(); wr("t1.after", 0, 0, 0);
    chk("t1.done_off", 32'(done), 0);
    chk("t1.busy_off", 32'(busy), 0);
    chk("t1.count_hold", 32'(count), 3);
    // T2
    open(12'd256);
    close = 1; tick(); idle_in();
    wr("t2.commit", 0, 0, 0);
    tick(); wr("t2.hdr", 1, 256, 0);
    chk("t2.done", 32'(done), 1);
    chk("t2.count", 32'(count), 0);
    tick();
    // T3 overflow at FRAME_DEPTH=4
    open(12'd0);
    beat(10'd1, 0); tick(); wr("t3.b1", 1, 1, 1);
    beat(10'd2, 0); tick(); wr("t3.b2", 1, 2, 2);
    beat(10'd3, 0); tick(); wr("t3.b3", 1, 3, 3);
    chk("t3.ovf_full", 32'(overflow), 0);
    beat(10'd4, 0); tick(); wr("t3.b4", 0, 0, 0);
    chk("t3.ovf4", 32'(overflow), 1);
    chk("t3.ready4", 32'(in_ready), 1);
    beat(10'd5, 1); tick(); wr("t3.b5", 0, 0, 0);
    chk("t3.ready5", 32'(in_ready), 0);
    idle_in(); tick(); wr("t3.hdr", 1, 0, 3);
    chk("t3.done", 32'(done), 1);
    chk("t3.ovf", 32'(overflow), 1);
    tick();
    // T4 start while busy
    open(12'd128);
    chk("t4.ovf_clr", 32'(overflow), 0);
    chk("t4.count_clr", 32'(count), 0);
    start = 1; frame_baddr = 12'd512; tick(); start = 0;
    wr("t4.restart", 0, 0, 0);
    chk("t4.busy", 32'(busy), 1);
    beat(10'd7, 1); tick(); wr("t4.b0", 1, 129, 7);
    idle_in(); tick(); wr("t4.hdr", 1, 128, 1);
    chk("t4.done", 32'(done), 1);
    tick(); wr("t4.after", 0, 0, 0);
    // T5 address wrap; last beat and close together
    open(12'd4094);
    beat(10'd3, 0); tick(); wr("t5.b0", 1, 4095, 3);
    beat(10'd4, 1); close = 1; tick(); wr("t5.b1", 1, 0, 4);
    idle_in(); tick(); wr("t5.hdr", 1, 4094, 2);
    chk("t5.done", 32'(done), 1);
    tick(); wr("t5.single_commit", 0, 0, 0);
    chk("t5.busy", 32'(busy), 0);
    // T6 mid-frame reset aborts
    open(12'd64);
    beat(10'd1, 0); tick(); wr("t6.b0", 1, 65, 1);
    beat(10'd2, 0); tick(); wr("t6.b1", 1, 66, 2);
    rst = 1; idle_in(); tick(); rst = 0;
    wr("t6.rst", 0, 0, 0);
    chk("t6.rst_addr", 32'(mem_waddr), 0);
    chk("t6.rst_ready", 32'(in_ready), 0);
    chk("t6.rst_busy", 32'(busy), 0);
    chk("t6.rst_count", 32'(count), 0);
    tick(); wr("t6.no_hdr", 0, 0, 0);
    chk("t6.no_done", 32'(done), 0);
    // clr aborts too
    open(12'd300);
    beat(10'd8, 0); tick(); wr("clr.b0", 1, 301, 8);
    clr = 1; idle_in(); tick(); clr = 0;
    wr("clr.abort", 0, 0, 0);
    chk("clr.busy", 32'(busy), 0);
    chk("clr.count", 32'(count), 0);
    open(12'd64);
    beat(10'd9, 1); tick(); wr("t6.new_b0", 1, 65, 9);
    idle_in(); tick(); wr("t6.new_hdr", 1, 64, 1);
    chk("t6.new_done", 32'(done), 1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: testbench did not complete");
    $fatal(1, "timeout");
  end
endmodule
